seg_decode: RTL

SEG_DECODE -- requirements
Module: seg_decode

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_evt_fifo.sv | 53 +++++
 rtl/seg_decode.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: segment pattern constants, display geometry and event record shared by
// the seven-segment decoder and the display encoder.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;

    // Bit 6 is segment a, bit 0 is segment g.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;

    typedef struct packed {
        logic [2:0]         pos;
        logic [DIGIT_W-1:0] val;
        logic               err;
    } evt_t;

endpackage

// File: rtl/seg_evt_fifo.sv
// seg_evt_fifo: 2-entry valid/ready event buffer, head entry drives the outputs;
// ovf pulses when a push meets a full buffer with no simultaneous pop.
module seg_evt_fifo
    import seg_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  evt_t din,
    input  logic ready,
    output logic valid,
    output evt_t dout,
    output logic ovf
);

    evt_t       e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop, push_ok;

    assign valid   = cnt_q != 2'd0;
    assign dout    = e0_q;
    assign pop     = valid && ready;
    assign push_ok = push && (cnt_q != 2'd2 || pop);
    assign ovf     = push && !push_ok;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (pop) begin
            e0_d  = e1_q;
            cnt_d = cnt_d - 2'd1;
        end
        if (push_ok) begin
            if (cnt_d == 2'd0) e0_d = din;
            else e1_d = din;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_decode.sv
// seg_decode: debounced seven-segment display snooper producing per-digit values and change events.
// Define SEG_DECODE_HEX_EN to also decode the hex glyphs A..F.
module seg_decode
    import seg_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_DIGITS-1:0]         num_csn,
    input  logic [6:0]                    num_a_g,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]         digit_vld,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [2:0]                    evt_pos,
    output logic [DIGIT_W-1:0]            evt_val,
    output logic                          evt_err,
    output logic [7:0]                    err_cnt,
    output logic [7:0]                    ovf_cnt
);

    localparam logic [3:0] SC = 4'(STABLE_CYC);

    function automatic logic [DIGIT_W:0] seg_val(input logic [6:0] s);
        case (s)
            SEG_0:   seg_val = {1'b1, 4'd0};
            SEG_1:   seg_val = {1'b1, 4'd1};
            SEG_2:   seg_val = {1'b1, 4'd2};
            SEG_3:   seg_val = {1'b1, 4'd3};
            SEG_4:   seg_val = {1'b1, 4'd4};
            SEG_5:   seg_val = {1'b1, 4'd5};
            SEG_6:   seg_val = {1'b1, 4'd6};
            SEG_7:   seg_val = {1'b1, 4'd7};
            SEG_8:   seg_val = {1'b1, 4'd8};
            SEG_9:   seg_val = {1'b1, 4'd9};
`ifdef SEG_DECODE_HEX_EN
            SEG_A:   seg_val = {1'b1, 4'd10};
            SEG_B:   seg_val = {1'b1, 4'd11};
            SEG_C:   seg_val = {1'b1, 4'd12};
            SEG_D:   seg_val = {1'b1, 4'd13};
            SEG_E:   seg_val = {1'b1, 4'd14};
            SEG_F:   seg_val = {1'b1, 4'd15};
`endif
            default: seg_val = '0;
        endcase
    endfunction

    logic [14:0]                   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic                          acc_q, acc_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         vld_q, vld_d;
    logic [7:0]                    err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic [NUM_DIGITS-1:0]         csn, lo;
    logic [6:0]                    ag;
    logic [2:0]                    pos;
    logic [DIGIT_W:0]              dec;
    logic [DIGIT_W-1:0]            cur;
    logic                          push, err, ovf;
    evt_t                          evt, head;

    assign sync1_d = {num_csn, num_a_g};
    assign sync2_d = sync1_q;
    assign cnt_d   = (sync1_q != sync2_q) ? 4'd1 : (cnt_q == SC ? cnt_q : cnt_q + 4'd1);
    // The acceptance is registered so the decode sees a settled pattern one cycle later.
    assign acc_d   = (cnt_d == SC) && (cnt_q != SC);
    assign csn     = sync2_q[14:7];
    assign ag      = sync2_q[6:0];
    assign lo      = ~csn;
    assign dec     = seg_val(ag);
    assign cur     = digits_q[{pos, 2'b00} +: DIGIT_W];

    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (lo[i]) pos = 3'(i);
    end

    always_comb begin
        digits_d = digits_q;
        vld_d    = vld_q;
        push     = 1'b0;
        err      = 1'b0;
        evt      = '0;
        if (acc_q && csn != 8'hFF) begin
            if ((lo & (lo - 8'd1)) != 8'd0) begin
                push = 1'b1;
                err  = 1'b1;
                evt  = '{pos: 3'd0, val: 4'd0, err: 1'b1};
            end else if (ag == SEG_BLANK) begin
                vld_d[pos] = 1'b0;
            end else if (dec[DIGIT_W]) begin
                if (dec[DIGIT_W-1:0] != cur || !vld_q[pos]) begin
                    digits_d[{pos, 2'b00} +: DIGIT_W] = dec[DIGIT_W-1:0];
                    vld_d[pos] = 1'b1;
                    push       = 1'b1;
                    evt        = '{pos: pos, val: dec[DIGIT_W-1:0], err: 1'b0};
                end
            end else begin
                push = 1'b1;
                err  = 1'b1;
                evt  = '{pos: pos, val: 4'd0, err: 1'b1};
            end
        end
    end

    assign err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    assign ovf_cnt_d = (ovf && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= 4'd0;
            acc_q     <= 1'b0;
            digits_q  <= '0;
            vld_q     <= '0;
            err_cnt_q <= 8'd0;
            ovf_cnt_q <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            digits_q  <= digits_d;
            vld_q     <= vld_d;
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    seg_evt_fifo u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (push),
        .din   (evt),
        .ready (evt_ready),
        .valid (evt_valid),
        .dout  (head),
        .ovf   (ovf)
    );

    assign digits    = digits_q;
    assign digit_vld = vld_q;
    assign evt_pos   = head.pos;
    assign evt_val   = head.val;
    assign evt_err   = head.err;
    assign err_cnt   = err_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
